// File: rtl/pipe_ctrl.sv
// Pipeline stall controller with a divide sequencer (IDLE/BUSY/DONE), timeout abort
// and a saturating count of stalled cycles.
module pipe_ctrl #(
    parameter int DIV_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             div_req,
    input  logic             div_ready,
    input  logic             flush,
    output logic [5:0]       stall,
    output logic             div_start,
    output logic             div_cancel,
    output logic             div_done,
    output logic             div_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int BCNT_W = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DIV_TIMEOUT - 1);

    localparam logic [5:0] STALL_NONE  = 6'b000000;
    localparam logic [5:0] STALL_TO_EX = 6'b001111;
    localparam logic [5:0] STALL_TO_ID = 6'b000111;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state;
    logic [BCNT_W-1:0] busy_cnt;

    // A flush kills every in-flight instruction, so nothing needs holding that cycle.
    always_comb begin
        stall = STALL_NONE;
        if (rst || flush) begin
            stall = STALL_NONE;
        end else if (stallreq_ex || (state == IDLE && div_req) || state == BUSY) begin
            stall = STALL_TO_EX;
        end else if (stallreq_id) begin
            stall = STALL_TO_ID;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy_cnt    <= '0;
            div_start   <= 1'b0;
            div_cancel  <= 1'b0;
            div_done    <= 1'b0;
            div_timeout <= 1'b0;
        end else begin
            div_start   <= 1'b0;
            div_cancel  <= 1'b0;
            div_done    <= 1'b0;
            div_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (div_req && !flush) begin
                        state     <= BUSY;
                        busy_cnt  <= '0;
                        div_start <= 1'b1;
                    end
                end
                BUSY: begin
                    // Flush beats div_ready, div_ready beats timeout.
                    if (flush) begin
                        state      <= IDLE;
                        div_cancel <= 1'b1;
                    end else if (div_ready) begin
                        state    <= DONE;
                        div_done <= 1'b1;
                    end else if (busy_cnt == BCNT_LAST) begin
                        state       <= IDLE;
                        div_cancel  <= 1'b1;
                        div_timeout <= 1'b1;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall != STALL_NONE && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random stimulus,
// compared cycle by cycle against a behavioural model of the divide sequence.
module tb_pipe_ctrl;

    localparam int DIV_TIMEOUT = 8;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             stallreq_id = 1'b0;
    logic             stallreq_ex = 1'b0;
    logic             div_req = 1'b0;
    logic             div_ready = 1'b0;
    logic             flush = 1'b0;
    logic [5:0]       stall;
    logic             div_start;
    logic             div_cancel;
    logic             div_done;
    logic             div_timeout;
    logic [CNT_W-1:0] stall_cycles;

    pipe_ctrl #(.DIV_TIMEOUT(DIV_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .div_req      (div_req),
        .div_ready    (div_ready),
        .flush        (flush),
        .stall        (stall),
        .div_start    (div_start),
        .div_cancel   (div_cancel),
        .div_done     (div_done),
        .div_timeout  (div_timeout),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: is a divide in flight, how many cycles has it spent
    // waiting, is the result being handed over this cycle, and pending pulses.
    bit dividing  = 1'b0;
    bit finishing = 1'b0;
    int age       = 0;
    bit e_start   = 1'b0;
    bit e_cancel  = 1'b0;
    bit e_timeout = 1'b0;
    int e_count   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    function automatic int model_stall(input bit f, input bit req, input bit sid, input bit sex);
        if (rst || f) return 6'b000000;
        if (sex || dividing || (!dividing && !finishing && req)) return 6'b001111;
        if (sid) return 6'b000111;
        return 6'b000000;
    endfunction

    task automatic model_reset();
        dividing  = 1'b0;
        finishing = 1'b0;
        age       = 0;
        e_start   = 1'b0;
        e_cancel  = 1'b0;
        e_timeout = 1'b0;
        e_count   = 0;
    endtask

    // Drive one cycle's inputs (at a falling edge), check, then advance the model
    // to what the next rising edge should produce.
    task automatic step(input bit f, input bit req, input bit rdy, input bit sid, input bit sex);
        int exp_stall;
        flush = f; div_req = req; div_ready = rdy; stallreq_id = sid; stallreq_ex = sex;
        #1;
        exp_stall = model_stall(f, req, sid, sex);
        check("stall", int'(stall), exp_stall);
        check("div_start", int'(div_start), int'(e_start));
        check("div_cancel", int'(div_cancel), int'(e_cancel));
        check("div_done", int'(div_done), int'(finishing));
        check("div_timeout", int'(div_timeout), int'(e_timeout));
        check("stall_cycles", int'(stall_cycles), e_count);

        if (exp_stall != 0 && e_count < CNT_MAX) e_count++;
        e_start = 0; e_cancel = 0; e_timeout = 0;
        if (finishing) begin
            finishing = 0;
        end else if (dividing) begin
            if (f) begin
                dividing = 0; e_cancel = 1;
            end else if (rdy) begin
                dividing = 0; finishing = 1;
            end else if (age == DIV_TIMEOUT) begin
                dividing = 0; e_cancel = 1; e_timeout = 1;
            end else begin
                age++;
            end
        end else if (req && !f) begin
            dividing = 1; age = 1; e_start = 1;
        end
    endtask

    task automatic cycle(input bit f, input bit req, input bit rdy, input bit sid, input bit sex);
        @(negedge clk);
        step(f, req, rdy, sid, sex);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, int'(stall), 0);
        check({tag, "_start"}, int'(div_start), 0);
        check({tag, "_cancel"}, int'(div_cancel), 0);
        check({tag, "_done"}, int'(div_done), 0);
        check({tag, "_timeout"}, int'(div_timeout), 0);
        check({tag, "_count"}, int'(stall_cycles), 0);
    endtask

    // Assert reset between clock edges with busy-looking inputs; outputs must
    // clear at once and no cancel may follow.
    task automatic reset_mid_cycle(input string tag);
        @(posedge clk);
        #2;
        rst = 1'b1; div_req = 1'b1; stallreq_ex = 1'b1; stallreq_id = 1'b1;
        #1;
        check_all_zero(tag);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        #1;
        check_all_zero("reset");
        @(negedge clk);
        check_all_zero("reset_hold");
        rst = 1'b0;
        step(0, 0, 0, 0, 0);

        // stallreq_id alone for two cycles
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);
        check("id_stall_count", int'(stall_cycles), 2);

        // divide completing 5 cycles after start, div_req held
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);
        check("done_seen", int'(div_done), 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // timeout with no div_ready
        for (int i = 0; i < DIV_TIMEOUT + 3; i++) cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);

        // flush and div_ready together in BUSY
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(1, 1, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check("flush_cancel", int'(div_cancel), 1);

        // div_req drops mid-BUSY: must keep waiting
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // EX stall overrides ID stall
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);

        // saturation of the stall counter
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);
        check("count_saturated", int'(stall_cycles), CNT_MAX);

        // reset asserted during BUSY
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        reset_mid_cycle("rst_busy");
        cycle(0, 0, 0, 0, 0);

        // random traffic with a mid-run reset
        for (int n = 0; n < 800; n++) begin
            if (n == 400) reset_mid_cycle("rst_rand");
            cycle(($urandom_range(15) == 0), ($urandom_range(2) != 0), ($urandom_range(9) == 0),
                  ($urandom_range(3) == 0), ($urandom_range(5) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
